uart_dump_tx: RTL and testbench

- Serial transmitter that reads back song data stored in the note regfile and sends it out over UART (8N1, LSB first).
- It is the opposite direction of the UART receive path that loads the regfile.
- It sits beside the regfile and drives its read port while in writing mode, so a PC can verify a downloaded song.
- Each 12-bit word is sent as two bytes: high byte first, then low byte.

---
 rtl/uart_dump_tx.sv | 167 ++++++++++++++++
 tb/tb_uart_dump_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_dump_tx.sv
// uart_dump_tx: reads 12-bit song words back out of the note regfile and
// sends each one as two UART frames (high byte {4'b0, word[11:8]} first,
// then word[7:0]), 8 data bits LSB first, one stop bit.
// Optional build macro UART_DUMP_PARITY_EN adds an even-parity bit after
// the data bits of every frame.
module uart_dump_tx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_cnt
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LOAD,
        START_BIT,
        DATA_BITS,
`ifdef UART_DUMP_PARITY_EN
        PARITY,
`endif
        STOP_BIT,
        NEXT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] word_cnt_q;
    logic [11:0]       word_q;
    logic [7:0]        byte_q;
    logic              byte_sel_q;   // 0: high byte in flight, 1: low byte
    logic [2:0]        bit_idx_q;
    logic [CW-1:0]     baud_cnt_q;
    logic              bit_end;
    logic              in_bit;
    logic              last_word;

    assign bit_end   = (baud_cnt_q == '0);
    assign last_word = ((word_cnt_q + ADDR_W'(1)) == len_q);

`ifdef UART_DUMP_PARITY_EN
    assign in_bit = state_q inside {START_BIT, DATA_BITS, PARITY, STOP_BIT};
`else
    assign in_bit = state_q inside {START_BIT, DATA_BITS, STOP_BIT};
`endif

    assign rd_addr  = rd_addr_q;
    assign word_cnt = word_cnt_q;
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and serial line value.
    // NOTE: every output of this block is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        tx      = 1'b1;
        case (state_q)
            IDLE:      if (start) state_d = (len == '0) ? DONE : FETCH;
            FETCH:     state_d = LOAD;
            LOAD:      state_d = START_BIT;
            START_BIT: begin
                tx = 1'b0;
                if (bit_end) state_d = DATA_BITS;
            end
            DATA_BITS: begin
                tx = byte_q[bit_idx_q];
`ifdef UART_DUMP_PARITY_EN
                if (bit_end && bit_idx_q == 3'd7) state_d = PARITY;
`else
                if (bit_end && bit_idx_q == 3'd7) state_d = STOP_BIT;
`endif
            end
`ifdef UART_DUMP_PARITY_EN
            PARITY: begin
                tx = ^byte_q;
                if (bit_end) state_d = STOP_BIT;
            end
`endif
            STOP_BIT:  if (bit_end) state_d = byte_sel_q ? NEXT : START_BIT;
            NEXT:      state_d = last_word ? DONE : FETCH;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Baud counter: reloaded when a bit begins, counts down to the bit end.
    always_ff @(posedge clk) begin
        if (!rst_n)                         baud_cnt_q <= '0;
        else if (state_q == LOAD)           baud_cnt_q <= BAUD_RELOAD;
        else if (in_bit && bit_end)         baud_cnt_q <= BAUD_RELOAD;
        else if (in_bit)                    baud_cnt_q <= baud_cnt_q - CW'(1);
    end

    // Captured word; always written in LOAD before any bit of it is used.
    // NOTE: pure data register with no reset -- nothing reads it until LOAD
    // has refilled it, so clearing it would only cost reset routing.
    always_ff @(posedge clk) begin
        if (state_q == LOAD) word_q <= rd_data;
    end

    // Dump bookkeeping: length latch, address/word counters, byte and bit select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q      <= '0;
            rd_addr_q  <= '0;
            word_cnt_q <= '0;
            byte_q     <= '0;
            byte_sel_q <= 1'b0;
            bit_idx_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q      <= len;
                        rd_addr_q  <= '0;
                        word_cnt_q <= '0;
                    end
                end
                LOAD: begin
                    byte_q     <= {4'b0000, rd_data[11:8]};
                    byte_sel_q <= 1'b0;
                    bit_idx_q  <= '0;
                end
                DATA_BITS: begin
                    if (bit_end) bit_idx_q <= bit_idx_q + 3'd1;
                end
                STOP_BIT: begin
                    if (bit_end && !byte_sel_q) begin
                        byte_sel_q <= 1'b1;
                        byte_q     <= word_q[7:0];
                    end
                end
                NEXT: begin
                    word_cnt_q <= word_cnt_q + ADDR_W'(1);
                    if (!last_word) rd_addr_q <= rd_addr_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_dump_tx.sv
// tb_uart_dump_tx: drives uart_dump_tx against a small regfile model and
// compares the serial line, handshakes and counters with a reference built
// from the frame format (bit list expanded by DIV clocks per bit).
module tb_uart_dump_tx;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int ADDR_W   = 8;
    localparam int BUDGET   = 5000;
`ifdef UART_DUMP_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] len = '0;
    logic [ADDR_W-1:0] rd_addr;
    logic [11:0]       rd_data;
    logic              tx;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] word_cnt;

    logic [11:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    uart_dump_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .len     (len),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx      (tx),
        .busy    (busy),
        .done    (done),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Regfile read port: data valid one clock after the address.
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One dump of n words from mem[0..n-1]. restart_at: sample index at which a
    // second start (with a different len) is pulsed, -1 for none. rst_at:
    // sample index at which rst_n is pulled low for one cycle, -1 for none.
    // Sample index 0 is the first cycle after the accepted start.
    task automatic run_dump(input int n, input int restart_at, input int rst_at);
        bit          tq[$];
        bit          bq[$];
        int          aq[$];
        int          wq[$];
        bit          exp_tx[$];
        logic [7:0]  exp_bytes[$];
        logic [7:0]  rx_bytes[$];
        int          addr_seq[$];
        logic [11:0] word;
        logic [7:0]  b;
        int          idx;
        int          done_idx_exp;
        int          bad;
        int          busy_cnt;
        int          s;
        int          k;
        bit          seen_done;

        // Reference: per word FETCH+LOAD idle cycles, two frames, one NEXT
        // cycle; the dump ends with the DONE cycle.
        for (int w = 0; w < n; w++) begin
            word = mem[w];
            exp_tx.push_back(1'b1);
            exp_tx.push_back(1'b1);
            for (int h = 0; h < 2; h++) begin
                b = (h == 0) ? {4'h0, word[11:8]} : word[7:0];
                exp_bytes.push_back(b);
                for (int c = 0; c < DIV; c++) exp_tx.push_back(1'b0);
                for (int i = 0; i < 8; i++)
                    for (int c = 0; c < DIV; c++) exp_tx.push_back(b[i]);
`ifdef UART_DUMP_PARITY_EN
                for (int c = 0; c < DIV; c++) exp_tx.push_back(^b);
`endif
                for (int c = 0; c < DIV; c++) exp_tx.push_back(1'b1);
            end
            exp_tx.push_back(1'b1);
        end
        exp_tx.push_back(1'b1);
        done_idx_exp = exp_tx.size() - 1;

        @(negedge clk);
        start = 1'b1;
        len   = ADDR_W'(n);
        @(negedge clk);
        start = 1'b0;
        len   = ADDR_W'($urandom);

        seen_done = 1'b0;
        for (idx = 0; idx < BUDGET; idx++) begin
            tq.push_back(tx);
            bq.push_back(busy);
            aq.push_back(int'(rd_addr));
            wq.push_back(int'(word_cnt));
            if (rst_at >= 0 && idx == rst_at + 1) break;
            if (done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
            start = (idx == restart_at);
            if (idx == restart_at) len = ADDR_W'(n + 2);
            rst_n = (idx != rst_at);
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b1;

        if (rst_at >= 0) begin
            check("rst_tx", tq[tq.size()-1], 1);
            check("rst_busy", bq[bq.size()-1], 0);
            check("rst_word_cnt", wq[wq.size()-1], 0);
            check("rst_rd_addr", aq[aq.size()-1], 0);
            check("rst_no_done", seen_done, 0);
            return;
        end

        check("done_seen", seen_done, 1);
        if (!seen_done) return;

        check("done_idx", idx, done_idx_exp);
        bad = 0;
        for (int c = 0; c < tq.size(); c++)
            if (c >= exp_tx.size() || tq[c] !== exp_tx[c]) bad++;
        check("tx_trace_bad_cycles", bad, 0);

        busy_cnt = 0;
        foreach (bq[c]) if (bq[c]) busy_cnt++;
        check("busy_cycles", busy_cnt, (n == 0) ? 0 : done_idx_exp);
        check("busy_at_done", bq[idx], 0);
        check("word_cnt_start", wq[0], 0);
        check("word_cnt_end", wq[idx], n);

        if (n > 0) begin
            foreach (aq[c])
                if (addr_seq.size() == 0 || addr_seq[addr_seq.size()-1] != aq[c])
                    addr_seq.push_back(aq[c]);
            check("rd_addr_steps", addr_seq.size(), n);
            for (int i = 0; i < addr_seq.size() && i < n; i++)
                check("rd_addr_value", addr_seq[i], i);
        end

        // UART receiver: find start edges, sample mid-bit.
        k = 1;
        while (k < tq.size()) begin
            if (tq[k-1] == 1'b1 && tq[k] == 1'b0 && k + NBITS*DIV <= tq.size()) begin
                s = k;
                for (int i = 0; i < 8; i++) b[i] = tq[s + (1+i)*DIV + DIV/2];
                rx_bytes.push_back(b);
`ifdef UART_DUMP_PARITY_EN
                check("parity_bit", tq[s + 9*DIV + DIV/2], ^b);
`endif
                check("stop_bit", tq[s + (NBITS-1)*DIV + DIV/2], 1);
                k = s + NBITS*DIV;
            end else begin
                k++;
            end
        end
        check("byte_count", rx_bytes.size(), exp_bytes.size());
        for (int i = 0; i < rx_bytes.size() && i < exp_bytes.size(); i++)
            check("rx_byte", rx_bytes[i], exp_bytes[i]);

        @(negedge clk);
        check("idle_done_low", done, 0);
        check("idle_busy_low", busy, 0);
        check("idle_tx_high", tx, 1);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 12'h000;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_word_cnt", word_cnt, 0);
        rst_n = 1'b1;

        mem[0] = 12'hA5C;
        run_dump(1, -1, -1);

        mem[0] = 12'h001; mem[1] = 12'hFFF; mem[2] = 12'h800;
        run_dump(3, -1, -1);

        run_dump(0, -1, -1);

        // Second start during DATA_BITS of the first byte of word 0.
        mem[0] = 12'($urandom); mem[1] = 12'($urandom);
        run_dump(2, 2 + DIV + 5, -1);

        // Reset during the start bit of the second byte, then a clean dump.
        run_dump(2, -1, 2 + NBITS*DIV + 3);
        mem[0] = 12'($urandom); mem[1] = 12'($urandom);
        run_dump(2, -1, -1);

        mem[0] = 12'h0F3; mem[1] = 12'h001;
        run_dump(2, -1, -1);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int a = 0; a < n; a++) mem[a] = 12'($urandom);
            run_dump(n, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
